online_otf_converter: RTL

Downstream stage of the radix-2 online divider. It consumes the MSB-first signed-digit quotient stream over the divider's `In_vd`/`In_rd`-style handshake. It performs on-the-fly conversion using Q/QM registers, so no carry-propagate adder is needed. After `NDIG` digits it presents the quotient as a two's-complement word over an `Out_vd`/`Out_rd` handshake.

---
 rtl/online_otf_converter_if.sv | 35 +++
 rtl/online_otf_converter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/online_otf_converter_if.sv
// Handshake bundle between the online divider, the on-the-fly converter
// and the quotient consumer. Signal names follow the divider's port naming.
//   master : environment side (drives digits and downstream ready)
//   slave  : converter side
interface online_otf_converter_if #(
  parameter int NDIG = 8
);
  logic [1:0]    q_value;
  logic          In_vd;
  logic          In_rd;
  logic [NDIG:0] q_word;
  logic          Out_vd;
  logic          Out_rd;
  logic          err;

  modport master (
    output q_value,
    output In_vd,
    input  In_rd,
    input  q_word,
    input  Out_vd,
    output Out_rd,
    input  err
  );

  modport slave (
    input  q_value,
    input  In_vd,
    output In_rd,
    output q_word,
    output Out_vd,
    input  Out_rd,
    output err
  );
endinterface

// File: rtl/online_otf_converter.sv
// On-the-fly converter: turns an MSB-first radix-2 signed-digit quotient
// stream into a two's-complement word using the Q / QM register pair
// (QM always equals Q - 1), so no carry-propagate adder is needed.
// Optional feature macro: OTF_ERR_EN (sticky illegal-digit flag on err).
module online_otf_converter #(
  parameter int NDIG = 8,
  parameter int CW   = $clog2(NDIG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  online_otf_converter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
  localparam logic [NDIG:0] Q_INIT   = {(NDIG + 1){1'b0}};
  localparam logic [NDIG:0] QM_INIT  = {(NDIG + 1){1'b1}};

  state_t          state_q, state_d;
  logic [NDIG:0]   q_q, q_d;
  logic [NDIG:0]   qm_q, qm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_rd_q, out_vd_q;
  logic            accept_s;

  // Next-state, digit conversion and counter update
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    qm_d     = qm_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ACCUM;
        q_d     = Q_INIT;
        qm_d    = QM_INIT;
        cnt_d   = {CW{1'b0}};
      end
      ST_ACCUM: begin
        if (bus.In_vd && in_rd_q) begin
          accept_s = 1'b1;
          // Digit 11 is illegal and converts exactly like 0
          case (bus.q_value)
            2'b01: begin
              q_d  = {q_q[NDIG-1:0], 1'b1};
              qm_d = {q_q[NDIG-1:0], 1'b0};
            end
            2'b10: begin
              q_d  = {qm_q[NDIG-1:0], 1'b1};
              qm_d = {qm_q[NDIG-1:0], 1'b0};
            end
            default: begin
              q_d  = {q_q[NDIG-1:0], 1'b0};
              qm_d = {qm_q[NDIG-1:0], 1'b1};
            end
          endcase
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.Out_rd) begin
          state_d = ST_IDLE;
          q_d     = Q_INIT;
          qm_d    = QM_INIT;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        q_d     = Q_INIT;
        qm_d    = QM_INIT;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, conversion registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      q_q      <= Q_INIT;
      qm_q     <= QM_INIT;
      cnt_q    <= {CW{1'b0}};
      in_rd_q  <= 1'b0;
      out_vd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      cnt_q    <= cnt_d;
      in_rd_q  <= (state_d == ST_ACCUM);
      out_vd_q <= (state_d == ST_DONE);
    end
  end

  assign bus.In_rd  = in_rd_q;
  assign bus.Out_vd = out_vd_q;
  assign bus.q_word = q_q;

`ifdef OTF_ERR_EN
  logic err_q;

  // Sticky illegal-digit flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept_s && (bus.q_value == 2'b11)) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
